// File: rtl/img_word_packer.sv
// Packs a stream of pixels into wide SRAM words, sixteen pixels per word,
// and writes a fixed number of words per load (two images back to back).
module img_word_packer #(
  parameter int PIX_W    = 8,
  parameter int WORD_PIX = 16,
  parameter int N_WORDS  = 2048
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [PIX_W:0]              in_data,
  output logic                        wr_en,
  output logic [$clog2(N_WORDS)-1:0]  wr_addr,
  output logic [PIX_W*WORD_PIX-1:0]   wr_data,
  output logic                        busy,
  output logic                        load_done
);

  localparam int WORD_W = PIX_W * WORD_PIX;
  localparam int ASM_W  = WORD_W - PIX_W;
  localparam int CNT_W  = $clog2(WORD_PIX);
  localparam int ADDR_W = $clog2(N_WORDS);
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(WORD_PIX - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_pixCnt;
  logic [ADDR_W-1:0]  r_wordCnt;
  logic [ASM_W-1:0]   r_asm;
  logic [WORD_W-1:0]  r_wrData;
  logic [ADDR_W-1:0]  r_wrAddr;
  logic               r_wrEn;
  logic               r_loadDone;

  logic [PIX_W-1:0]   w_pixel;
  logic               w_unused;
  logic               w_wordDone;
  logic               w_lastWord;

  // The top data bit is a sideband flag from the source and is not stored.
  assign w_pixel    = in_data[PIX_W-1:0];
  assign w_unused   = in_data[PIX_W];
  assign w_wordDone = in_valid && (r_pixCnt == LAST_PIX);
  assign w_lastWord = w_wordDone && (r_wordCnt == LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Leaving LOAD on the last accepting edge lets a pixel arriving during the
  // final write cycle be taken in IDLE as the start of the next load.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_nextState = LOAD;
      LOAD:    if (w_lastWord) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixCnt   <= '0;
      r_wordCnt  <= '0;
      r_asm      <= '0;
      r_wrData   <= '0;
      r_wrAddr   <= '0;
      r_wrEn     <= 1'b0;
      r_loadDone <= 1'b0;
    end else begin
      r_wrEn     <= 1'b0;
      r_loadDone <= 1'b0;
      if (in_valid) begin
        r_pixCnt <= r_pixCnt + CNT_W'(1);
        for (int k = 0; k < WORD_PIX - 1; k++) begin
          if (r_pixCnt == CNT_W'(k)) begin
            r_asm[k*PIX_W +: PIX_W] <= w_pixel;
          end
        end
        // The final slot goes straight into the output word, so the assembly
        // register is free to take the next word's first pixel immediately.
        if (w_wordDone) begin
          r_wrEn     <= 1'b1;
          r_wrAddr   <= r_wordCnt;
          r_wrData   <= {w_pixel, r_asm};
          r_loadDone <= w_lastWord;
          r_wordCnt  <= w_lastWord ? '0 : r_wordCnt + ADDR_W'(1);
        end
      end
    end
  end

  assign wr_en     = r_wrEn;
  assign wr_addr   = r_wrAddr;
  assign wr_data   = r_wrData;
  assign load_done = r_loadDone;
  assign busy      = (r_state == LOAD) || r_loadDone;

endmodule

// File: doc/img_word_packer.md
IMG_WORD_PACKER -- requirements
Module: img_word_packer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter WORD_PIX, default 16, meaning pixels per SRAM word.
REQ-003 SHALL have parameter N_WORDS, default 2048, meaning words per load (two images of 1024 words).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  high when in_data carries one image pixel.
REQ-007 SHALL have port in_data  input  9  pixel stream; bits [7:0] are the pixel, bit 8 is ignored.
REQ-008 SHALL have port wr_en  output  1  one-cycle high pulse per word write to the pixel SRAM.
REQ-009 SHALL have port wr_addr  output  11  word address: [10] image, [9:5] row, [4:0] col.
REQ-010 SHALL have port wr_data  output  128  packed word; pixel k at bits [8k+7:8k].
REQ-011 SHALL have port busy  output  1  high while a load is in progress.
REQ-012 SHALL have port load_done  output  1  one-cycle high pulse marking the final word write.

Function
REQ-013 SHALL implement FSM states IDLE and LOAD; reset state is IDLE.
REQ-014 IDLE -> LOAD SHALL occur on a clock edge that samples in_valid=1, and that pixel SHALL be accepted as pixel 0 of word 0.
REQ-015 In LOAD, a pixel SHALL be accepted only on an edge that samples in_valid=1; in_valid=0 cycles (gaps) SHALL pause packing with no loss and no write.
REQ-016 The nth accepted pixel of a word (n = 0..15, first accepted = 0) SHALL be placed in slot n of the assembly register; pix_cnt is 4 bits and wraps 15 -> 0.
REQ-017 The edge that accepts slot 15 SHALL load the output register with the complete word, and in the following cycle wr_en=1 with wr_addr = word_cnt.
REQ-018 word_cnt (11 bits, starting at 0) SHALL increment by 1 after each word write.
REQ-019 wr_en SHALL be high for exactly one cycle per word; wr_data and wr_addr SHALL hold their values until the next write.
REQ-020 Acceptance of pixel 0 of the next word SHALL be allowed in the same cycle wr_en is high, with no interference with the word being written.
REQ-021 On the write of word N_WORDS-1 (wr_addr=0x7FF), load_done SHALL be 1 in the same cycle as that wr_en.
REQ-022 The FSM SHALL then return to IDLE with word_cnt and pix_cnt cleared.
REQ-023 busy SHALL be 1 from the cycle after the first accepted pixel through the final wr_en cycle inclusive.
REQ-024 A pixel with in_valid=1 in the final wr_en cycle SHALL be sampled in IDLE and SHALL start a new load at address 0.
REQ-025 Write throughput SHALL be one word per 16 accepted pixels, with no stall cycles required from the source.

Reset
REQ-026 While rst_n=0, all outputs SHALL be 0 and FSM, pix_cnt, word_cnt, assembly and output registers SHALL be cleared.
REQ-027 Reset asserted mid-load SHALL discard any partial word; no wr_en SHALL be produced for it, and the next load SHALL start at wr_addr 0.

Verification
REQ-028 Scenario: rst_n pulsed low with in_valid toggling -> wr_en, busy, load_done, wr_addr, wr_data all 0 during and after reset until a pixel is accepted.
REQ-029 Scenario: 32768 contiguous pixels with value i mod 256 -> first write has wr_addr 0x000 and wr_data 0x0F0E0D0C0B0A09080706050403020100; 2048 wr_en pulses total; last write wr_addr 0x7FF with load_done=1; busy=0 on the next cycle.
REQ-030 Scenario: pixels 0..7, then in_valid low 5 cycles, then pixels 8..15 -> exactly one wr_en, occurring the cycle after pixel 15, wr_data slot n = n; no wr_en during the gap.
REQ-031 Scenario: in_data[8]=1 on every pixel -> wr_data is identical to the same stream with bit 8 = 0.
REQ-032 Scenario: rst_n low after 20 accepted pixels, then a new stream -> no wr_en for the discarded pixels; first new write has wr_addr 0x000 with the new pixels 0..15.
REQ-033 Scenario: second full load starting in the cycle of load_done -> its first pixel is captured, and its first write has wr_addr 0x000 with correct contents.
